instr_class_profiler: RTL and testbench
=======================================

INSTR_CLASS_PROFILER -- requirements
Module: instr_class_profiler

Interface
REQ-001 SHALL have parameter LANES, default 2, number of instruction lanes retired per cycle (1..4).
REQ-002 SHALL have parameter CNT_W, default 32, counter width in bits (8..64).
REQ-003 SHALL have parameter SATURATE, default 1; 1 = counters clamp, 0 = counters wrap.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  count enable; low = counters hold.
REQ-007 SHALL have port clear  input  1  single-cycle pulse that zeroes live counters and overflow flags.
REQ-008 SHALL have port instr  input  LANES*32  executed instructions, lane i at bits [32i+31:32i].
REQ-009 SHALL have port instr_valid  input  LANES  per-lane retire strobe.
REQ-010 SHALL have port snap_req  input  1  pulse that copies live counters into the shadow bank.
REQ-011 SHALL have port rd_en  input  1  shadow read request.
REQ-012 SHALL have port rd_addr  input  4  class index to read.
REQ-013 SHALL have port rd_data  output  CNT_W  shadow counter value.
REQ-014 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-015 SHALL have port ovf  output  11  sticky per-class overflow flags.

Function
REQ-016 SHALL classify each lane into one of 11 classes: 0 LOAD, 1 STORE, 2 ADD, 3 BITWISE, 4 SHIFT, 5 COMPARE, 6 BRANCH, 7 JUMP, 8 SYSTEM, 9 ATOMIC, 10 OTHER.
REQ-017 SHALL decode: opcode 0000011 -> LOAD; 0100011 -> STORE; 1100011 -> BRANCH; 1101111 or 1100111 -> JUMP; 1110011 -> SYSTEM; 0101111 -> ATOMIC.
REQ-018 SHALL decode opcode 0010011 by funct3, and 0110011 with funct7 0000000/0100000 by funct3: 000 -> ADD; 100/110/111 -> BITWISE; 001/101 -> SHIFT; 010/011 -> COMPARE.
REQ-019 SHALL map every other encoding, including 0110011 with funct7 0000001, to OTHER.
REQ-020 SHALL, when enable=1, add to each class counter the number of valid lanes of that class in the same cycle (0..LANES); result visible the next cycle.
REQ-021 SHALL, with SATURATE=1, clamp at 2^CNT_W-1; with SATURATE=0, wrap modulo 2^CNT_W; in both cases set the class ovf bit when the true sum exceeds 2^CNT_W-1.
REQ-022 SHALL keep ovf bits set until clear or rst.
REQ-023 SHALL give clear priority over the same-cycle increments: counters and ovf are 0 on the next cycle.
REQ-024 SHALL, on snap_req, load the shadow bank with live values as they were before that cycle's update; snap_req with clear captures the pre-clear values.
REQ-025 SHALL return rd_data = shadow[rd_addr] with rd_valid=1 exactly one cycle after rd_en; rd_valid=0 otherwise.
REQ-026 SHALL return shadow contents from before a snap_req issued in the same cycle as rd_en.
REQ-027 SHALL return 0 with rd_valid=1 for rd_addr 11..15.
REQ-028 SHALL ignore instr for lanes with instr_valid=0.

Reset
REQ-029 SHALL, on rst, zero all live counters, the shadow bank, ovf, rd_data and rd_valid; rst overrides clear, snap_req and rd_en.
REQ-030 SHALL abandon any read in flight at rst; rd_valid is 0 in the cycle after rst.

Structure
REQ-031 SHALL define the class enum, NUM_CLASSES=11 and the opcode/funct constants in shared package profiler_pkg.
REQ-032 SHALL place per-lane decode in combinational sub-module instr_classifier (32-bit instruction -> class), instantiated LANES times.

Verification
REQ-033 SHALL cover: LANES=2, both lanes ADDI (0x00100093) for 5 cycles, then snap and read addr 2 -> rd_data=10, rd_valid=1 one cycle after rd_en.
REQ-034 SHALL cover: lane0 LW (0x00002003), lane1 SW (0x00002023) with enable=0 for 3 cycles, then enable=1 for 2 cycles -> LOAD=2, STORE=2.
REQ-035 SHALL cover: CNT_W=8, SATURATE=1, 300 BEQ (0x00000063) -> BRANCH=255, ovf[6]=1; with SATURATE=0 -> BRANCH=44, ovf[6]=1.
REQ-036 SHALL cover: clear asserted with 2 valid ADDs in the same cycle -> ADD=0 and ovf=0 next cycle; snap_req in that cycle -> shadow holds the pre-clear value.
REQ-037 SHALL cover: MUL (0x02000033) and LUI (0x000000B7) -> OTHER=2; read addr 13 -> rd_data=0, rd_valid=1.
REQ-038 SHALL cover: rst asserted while rd_en is pending -> rd_valid=0 and every counter, shadow entry and ovf bit is 0.

Source files
------------

// File: rtl/profiler_pkg.sv
// profiler_pkg
//   Shared definitions for the instruction-class profiler: class encoding,
//   class count, RV32 opcode/funct constants and the ALU funct3 -> class map.
package profiler_pkg;

    localparam int NUM_CLASSES = 11;
    localparam int CLS_W       = 4;

    typedef enum logic [CLS_W-1:0] {
        CLS_LOAD    = 4'd0,
        CLS_STORE   = 4'd1,
        CLS_ADD     = 4'd2,
        CLS_BITWISE = 4'd3,
        CLS_SHIFT   = 4'd4,
        CLS_COMPARE = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JUMP    = 4'd7,
        CLS_SYSTEM  = 4'd8,
        CLS_ATOMIC  = 4'd9,
        CLS_OTHER   = 4'd10
    } instr_class_e;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 values that keep a register-register op in the base integer set
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    function automatic instr_class_e alu_class(input logic [2:0] f3);
        instr_class_e c;
        case (f3)
            F3_ADD:                 c = CLS_ADD;
            F3_XOR, F3_OR, F3_AND:  c = CLS_BITWISE;
            F3_SLL, F3_SR:          c = CLS_SHIFT;
            F3_SLT, F3_SLTU:        c = CLS_COMPARE;
            default:                c = CLS_OTHER;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_classifier.sv
// instr_classifier
//   Combinational decode of one 32-bit instruction into a profiler class.
//   Ports:
//     instr_i : instruction word
//     cls_o   : class index (profiler_pkg::instr_class_e encoding)
module instr_classifier
    import profiler_pkg::*;
(
    input  logic [31:0]      instr_i,
    output logic [CLS_W-1:0] cls_o
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    instr_class_e cls;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register/immediate fields do not affect the class.
    logic unused_fields;
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        cls = CLS_OTHER;
        case (opcode)
            OPC_LOAD:          cls = CLS_LOAD;
            OPC_STORE:         cls = CLS_STORE;
            OPC_BRANCH:        cls = CLS_BRANCH;
            OPC_JAL, OPC_JALR: cls = CLS_JUMP;
            OPC_SYSTEM:        cls = CLS_SYSTEM;
            OPC_AMO:           cls = CLS_ATOMIC;
            OPC_OP_IMM:        cls = alu_class(funct3);
            // M-extension (funct7 0000001) and anything else stays OTHER
            OPC_OP:            if (funct7 == F7_BASE || funct7 == F7_ALT)
                                   cls = alu_class(funct3);
            default:           cls = CLS_OTHER;
        endcase
    end

    assign cls_o = cls;

endmodule

// File: rtl/instr_class_profiler.sv
// instr_class_profiler
//   Counts retired instructions per class across LANES retire lanes, with a
//   shadow bank for coherent snapshot reads.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     enable        : count enable (low = counters hold)
//     clear         : zero live counters and overflow flags
//     instr         : LANES x 32-bit instructions, lane i at [32i+31:32i]
//     instr_valid   : per-lane retire strobe
//     snap_req      : copy live counters into shadow bank
//     rd_en/rd_addr : shadow read request / class index
//     rd_data       : shadow value, qualified by rd_valid one cycle later
//     ovf           : sticky per-class overflow flags
module instr_class_profiler
    import profiler_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [LANES*32-1:0]    instr,
    input  logic [LANES-1:0]       instr_valid,
    input  logic                   snap_req,
    input  logic                   rd_en,
    input  logic [3:0]             rd_addr,
    output logic [CNT_W-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [NUM_CLASSES-1:0] ovf
);

    logic [LANES-1:0][CLS_W-1:0] lane_cls;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        instr_classifier u_cls (
            .instr_i (instr[32*l +: 32]),
            .cls_o   (lane_cls[l])
        );
    end

    logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CLASSES-1:0][CNT_W-1:0] shadow_q, shadow_d;
    logic [NUM_CLASSES-1:0]            ovf_q, ovf_d;
    logic [CNT_W-1:0]                  rd_data_q, rd_data_d;
    logic                              rd_valid_q;

    // Per-class increment: number of valid lanes of that class (0..4).
    logic [NUM_CLASSES-1:0][2:0]       inc;
    // One extra bit so the carry-out flags overflow for both modes.
    logic [NUM_CLASSES-1:0][CNT_W:0]   sum;

    always_comb begin
        inc = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int l = 0; l < LANES; l++) begin
                if (instr_valid[l] && lane_cls[l] == CLS_W'(c))
                    inc[c] = inc[c] + 3'd1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        sum   = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            sum[c] = {1'b0, cnt_q[c]} + (CNT_W+1)'(inc[c]);
            if (clear) begin
                cnt_d[c] = '0;
                ovf_d[c] = 1'b0;
            end else if (enable) begin
                if (SATURATE != 0 && sum[c][CNT_W])
                    cnt_d[c] = '1;
                else
                    cnt_d[c] = sum[c][CNT_W-1:0];
                ovf_d[c] = ovf_q[c] | sum[c][CNT_W];
            end
        end
    end

    // Snapshot takes the pre-update (and pre-clear) live values.
    assign shadow_d = snap_req ? cnt_q : shadow_q;

    // Read uses the registered shadow, so a same-cycle snap is not visible.
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (rd_addr == 4'(c))
                rd_data_d = shadow_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            shadow_q   <= '0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_en;
            if (rd_en)
                rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_instr_class_profiler.sv
module tb_instr_class_profiler;
    import profiler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1, enable = 1'b0, clear = 1'b0, snap_req = 1'b0, rd_en = 1'b0;
    logic [63:0] instr = '0;
    logic [1:0]  instr_valid = '0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] rd_data_a;  logic rd_valid_a;  logic [10:0] ovf_a;
    logic [7:0]  rd_data_s;  logic rd_valid_s;  logic [10:0] ovf_s;
    logic [7:0]  rd_data_w;  logic rd_valid_w;  logic [10:0] ovf_w;

    always #5 clk = ~clk;

    instr_class_profiler #(.LANES(2), .CNT_W(32), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .ovf(ovf_a));

    instr_class_profiler #(.LANES(2), .CNT_W(8), .SATURATE(1)) u_sat8 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .ovf(ovf_s));

    instr_class_profiler #(.LANES(2), .CNT_W(8), .SATURATE(0)) u_wrap8 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w), .ovf(ovf_w));

    localparam logic [31:0] ADDI = 32'h00100093, LW  = 32'h00002003, SW  = 32'h00002023;
    localparam logic [31:0] BEQ  = 32'h00000063, MUL = 32'h02000033, LUI = 32'h000000B7;

    int     n_tests = 0, n_fail = 0;
    longint tru[11];   // unbounded true counts since last clear/rst
    longint shd[11];   // true counts captured at last snap
    longint rd_q[$];   // scoreboard of expected read results (true values)

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint e_sat8(input longint t);
        return (t > 255) ? 255 : t;
    endfunction

    // One clock: drive, let the edge happen, update model, check outputs.
    task automatic cyc(input logic r, input logic en, input logic clr, input logic snp,
                       input logic rde, input logic [3:0] ad,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] v,
                       input int c0, input int c1);
        logic [10:0] eo8, eo32;
        longint      e;
        rst = r; enable = en; clear = clr; snap_req = snp; rd_en = rde; rd_addr = ad;
        instr = {i1, i0}; instr_valid = v;
        @(posedge clk); #1;
        if (r) begin
            for (int c = 0; c < 11; c++) begin tru[c] = 0; shd[c] = 0; end
            rd_q.delete();
        end else begin
            if (rde) rd_q.push_back((ad < 11) ? shd[ad] : 0);
            if (snp) for (int c = 0; c < 11; c++) shd[c] = tru[c];
            if (clr) for (int c = 0; c < 11; c++) tru[c] = 0;
            else if (en) begin
                if (v[0]) tru[c0]++;
                if (v[1]) tru[c1]++;
            end
        end
        for (int c = 0; c < 11; c++) begin
            eo8[c]  = tru[c] > 255;
            eo32[c] = tru[c] > 64'h0000_0000_FFFF_FFFF;
        end
        chk("ovf32", 64'(ovf_a), 64'(eo32));
        chk("ovf_sat8", 64'(ovf_s), 64'(eo8));
        chk("ovf_wrap8", 64'(ovf_w), 64'(eo8));
        if (!r && rde) begin
            e = rd_q.pop_front();
            chk("rd_valid", 64'({rd_valid_a, rd_valid_s, rd_valid_w}), 64'(3'b111));
            chk("rd_data32", 64'(rd_data_a), 64'(e & 64'hFFFF_FFFF));
            chk("rd_data_sat8", 64'(rd_data_s), 64'(e_sat8(e)));
            chk("rd_data_wrap8", 64'(rd_data_w), 64'(e & 64'hFF));
        end else begin
            chk("rd_valid_idle", 64'({rd_valid_a, rd_valid_s, rd_valid_w}), 64'(0));
        end
    endtask

    task automatic idle();                  cyc(0,0,0,0,0,4'd0,0,0,2'b00,0,0); endtask
    task automatic rd(input logic [3:0] a); cyc(0,0,0,0,1,a,0,0,2'b00,0,0);    endtask
    task automatic snap();                  cyc(0,0,0,1,0,4'd0,0,0,2'b00,0,0); endtask
    task automatic clr();                   cyc(0,0,1,0,0,4'd0,0,0,2'b00,0,0); endtask
    task automatic run(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] v,
                       input int c0, input int c1);
        cyc(0,1,0,0,0,4'd0,i0,i1,v,c0,c1);
    endtask

    // Classification table: instruction and its independently known class.
    localparam int NT = 16;
    logic [31:0] t_ins [NT] = '{32'h0020C0B3, 32'h0020A0B3, 32'h402080B3, 32'h4020D0B3,
                                32'h00109093, 32'h0FF0F093, 32'h0010B093, 32'h0000006F,
                                32'h00008067, 32'h00000073, 32'h0020A02F, 32'h20000033,
                                32'h00002003, 32'h00002023, 32'h00000063, 32'h02000033};
    int          t_cls [NT] = '{3, 5, 2, 4, 4, 3, 5, 7, 7, 8, 9, 10, 0, 1, 6, 10};

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    initial begin
        cyc(1,0,0,0,0,4'd0,0,0,2'b00,0,0);
        cyc(1,0,0,0,0,4'd0,0,0,2'b00,0,0);
        rd(4'd0); rd(4'd2);

        // Both lanes ADDI for 5 cycles, then snap and read ADD.
        for (int i = 0; i < 5; i++) run(ADDI, ADDI, 2'b11, CLS_ADD, CLS_ADD);
        snap(); rd(4'd2);

        // LW/SW held off by enable, then counted.
        clr();
        for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,4'd0,LW,SW,2'b11,CLS_LOAD,CLS_STORE);
        for (int i = 0; i < 2; i++) run(LW, SW, 2'b11, CLS_LOAD, CLS_STORE);
        snap(); rd(4'd0); rd(4'd1);

        // 300 BEQ: saturate vs wrap at 8 bits.
        clr();
        for (int i = 0; i < 150; i++) run(BEQ, BEQ, 2'b11, CLS_BRANCH, CLS_BRANCH);
        snap(); rd(4'd6);

        // clear with same-cycle ADDs and snap: shadow keeps pre-clear values.
        for (int i = 0; i < 3; i++) run(ADDI, ADDI, 2'b11, CLS_ADD, CLS_ADD);
        cyc(0,1,1,1,0,4'd0,ADDI,ADDI,2'b11,CLS_ADD,CLS_ADD);
        rd(4'd2); rd(4'd6);
        // snap and read in the same cycle: read returns the older shadow.
        run(ADDI, ADDI, 2'b11, CLS_ADD, CLS_ADD);
        cyc(0,0,0,1,1,4'd2,0,0,2'b00,0,0);
        rd(4'd2); rd(4'd6);

        // MUL and LUI count as OTHER; out-of-range addresses read 0.
        clr();
        run(MUL, LUI, 2'b11, CLS_OTHER, CLS_OTHER);
        snap(); rd(4'd10); rd(4'd13); rd(4'd15);

        // Decode table on lane 0; lane 1 carries an invalid ADDI.
        clr();
        for (int i = 0; i < NT; i++) run(t_ins[i], ADDI, 2'b01, t_cls[i], CLS_ADD);
        run(ADDI, SW, 2'b10, CLS_ADD, CLS_STORE);
        snap();
        for (int a = 0; a < 11; a++) rd(4'(a));

        // rst while a read is requested: read abandoned, everything zero.
        for (int i = 0; i < 2; i++) run(LW, BEQ, 2'b11, CLS_LOAD, CLS_BRANCH);
        cyc(1,1,0,1,1,4'd0,LW,BEQ,2'b11,CLS_LOAD,CLS_BRANCH);
        for (int a = 0; a < 11; a++) rd(4'(a));
        snap();
        for (int a = 0; a < 11; a++) rd(4'(a));
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
